fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//  Upstream stage of the 1024-pt FFT core. Accepts a complex sample stream (valid/ready),
//  writes one frame of N samples into the core's input bank (RAM A port A), then pulses
//  fft_start and holds off new input until the core reports fft_done.
// PARAMETERS
//  N_LOG2   10   log2 of frame length N (1024); addresses are N_LOG2 bits
//  DATA_W   16   bits per real/imag component; sample word is 2*DATA_W (complex_t layout {r,i})
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         reset, synchronous, active-low
//  s_valid    in   1         input sample valid
//  s_ready    out  1         loader can accept a sample this cycle
//  s_data     in   2*DATA_W  input sample, complex_t {r,i}
//  s_last     in   1         marks final sample of a source frame
//  ram_en     out  1         RAM A port A enable
//  ram_we     out  1         RAM A port A write enable
//  ram_addr   out  N_LOG2    RAM A port A address
//  ram_din    out  2*DATA_W  RAM A port A write data
//  fft_start  out  1         one-cycle pulse: frame loaded, core may run
//  fft_done   in   1         core finished (level or pulse; sampled only in WAIT_FFT)
//  busy       out  1         high in ZERO_FILL, START, WAIT_FFT
//  err_short  out  1         one-cycle pulse: s_last seen before sample N-1
// BEHAVIOUR
//  Reset: state=LOAD, count=0, s_ready=0 for the reset cycle then 1; ram_en/we=0, ram_addr=0,
//   ram_din=0, fft_start=0, busy=0, err_short=0. Reset mid-frame discards partial frame, no start.
//  Handshake: beat accepted when s_valid&&s_ready. s_ready=1 only in LOAD (combinational of state).
//  Write path registered: accepted beat k -> next cycle ram_en=ram_we=1, ram_addr=addr(k),
//   ram_din=s_data; otherwise ram_en=ram_we=0 (addr/din hold).
//  count: N_LOG2-bit sample index, increments per accepted/zero-filled write; wraps to 0 on frame end.
//  States:
//   LOAD      accept beats. Beat with count==N-1 -> START (s_last ignored on it).
//             Beat with s_last && count<N-1 -> ZERO_FILL, err_short pulses next cycle.
//   ZERO_FILL s_ready=0; writes 0 at addr(count) each cycle until count==N-1 written -> START.
//   START     fft_start=1 for exactly one cycle (the cycle after the last write strobe) -> WAIT_FFT.
//   WAIT_FFT  s_ready=0; fft_done=1 -> LOAD, count=0. fft_done in any other state ignored.
//  Gaps in s_valid in LOAD: no write, count holds, no timeout.
//  s_last on beat N-1: normal completion, no error. Beats past N-1 without s_last start a new frame
//   only after WAIT_FFT exits (held off by s_ready=0).
// CONFIGURATION
//  FFT_LOAD_BITREV_EN defined: addr(k)=bit-reverse of k over N_LOG2 bits (DIT input order).
//  Not defined: addr(k)=k (natural order). Latency/handshake identical in both builds.
// STRUCTURE
//  fft_consts package: N_LOG2, complex_t, loader state enum, bitrev function.
//  Single module, no sub-modules; state register + count + one write-output register stage.
// TESTING
//  Ramp 0..1023 (r=k,i=-k), no gaps, macro off -> writes addr k=data k; fft_start one pulse 1 cycle after write 1023.
//  Same ramp, FFT_LOAD_BITREV_EN -> sample 1 at addr 512, sample 3 at 768, sample 1023 at 1023.
//  s_last on sample 99 -> err_short pulse once; addrs 100..1023 written 0; then fft_start.
//  Random s_valid gaps (50%) -> exactly 1024 writes, order preserved; s_ready=0 throughout WAIT_FFT until fft_done.
//  rst_n low after 500 beats -> no fft_start; next frame restarts at addr 0, 1024 beats needed.
//  Two back-to-back frames with fft_done after 20 cycles -> second frame accepted only after fft_done, one start each.

Source files
------------

// File: rtl/fft_consts.sv
// fft_consts: shared constants, sample layout, loader state encoding and bit-reversal helper
// for the 1024-point FFT core.
package fft_consts;

    localparam int N_LOG2 = 10;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] r;
        logic signed [DATA_W-1:0] i;
    } complex_t;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t ST_LOAD      = 2'd0;
    localparam loader_state_t ST_ZERO_FILL = 2'd1;
    localparam loader_state_t ST_START     = 2'd2;
    localparam loader_state_t ST_WAIT_FFT  = 2'd3;

    // Reverses the low w bits of k; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < w; b++) r[b] = k[w-1-b];
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader: loads one frame of N complex samples into FFT input RAM, zero-fills short frames,
// pulses fft_start and holds off input until fft_done. Define FFT_LOAD_BITREV_EN for bit-reversed addressing.
module fft_input_loader #(
    parameter int N_LOG2 = fft_consts::N_LOG2,
    parameter int DATA_W = fft_consts::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*DATA_W-1:0] s_data,
    input  logic                s_last,
    output logic                ram_en,
    output logic                ram_we,
    output logic [N_LOG2-1:0]   ram_addr,
    output logic [2*DATA_W-1:0] ram_din,
    output logic                fft_start,
    input  logic                fft_done,
    output logic                busy,
    output logic                err_short
);
    import fft_consts::*;

    localparam logic [N_LOG2-1:0] LAST = '1;

    loader_state_t     state;
    loader_state_t     state_next;
    logic [N_LOG2-1:0] count;
    logic              accept;
    logic              wr;
    logic              last_slot;

    function automatic logic [N_LOG2-1:0] addr_of(input logic [N_LOG2-1:0] k);
`ifdef FFT_LOAD_BITREV_EN
        return N_LOG2'(bitrev(32'(k), N_LOG2));
`else
        return k;
`endif
    endfunction

    // Gated by rst_n so the reset cycle itself shows not-ready and not-busy.
    assign s_ready   = rst_n && state == ST_LOAD;
    assign busy      = rst_n && state != ST_LOAD;
    assign accept    = s_valid && s_ready;
    assign wr        = accept || state == ST_ZERO_FILL;
    assign last_slot = count == LAST;

    always_comb begin
        state_next = state == ST_LOAD      ? (!accept ? ST_LOAD : last_slot ? ST_START : s_last ? ST_ZERO_FILL : ST_LOAD)
                   : state == ST_ZERO_FILL ? (last_slot ? ST_START : ST_ZERO_FILL)
                   : state == ST_START     ? ST_WAIT_FFT
                   :                         (fft_done ? ST_LOAD : ST_WAIT_FFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            count     <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            fft_start <= 1'b0;
            err_short <= 1'b0;
        end else begin
            state     <= state_next;
            ram_en    <= wr;
            ram_we    <= wr;
            fft_start <= state == ST_START;
            err_short <= accept && s_last && !last_slot;
            if (wr) begin
                ram_addr <= addr_of(count);
                ram_din  <= accept ? s_data : '0;
                count    <= count + N_LOG2'(1);
            end else if (state == ST_WAIT_FFT && fft_done) begin
                count    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: table-driven frame scenarios plus reset and back-to-back sequences;
// expected RAM writes are queued when beats are accepted and checked as strobes appear.
module tb_fft_input_loader;

    localparam int N_LOG2 = 10;
    localparam int DATA_W = 16;
    localparam int N      = 1 << N_LOG2;
`ifdef FFT_LOAD_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [2*DATA_W-1:0] s_data = '0;
    logic                s_last = 1'b0;
    logic                ram_en;
    logic                ram_we;
    logic [N_LOG2-1:0]   ram_addr;
    logic [2*DATA_W-1:0] ram_din;
    logic                fft_start;
    logic                fft_done = 1'b0;
    logic                busy;
    logic                err_short;

    fft_input_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .fft_start(fft_start), .fft_done(fft_done), .busy(busy), .err_short(err_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_LOG2-1:0]   addr;
        logic [2*DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        string name;
        int    n;
        int    last_idx;
        bit    gaps;
        int    exp_err;
    } vec_t;

    wr_t  exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   starts = 0;
    int   errs = 0;
    int   writes = 0;
    logic prev_en = 1'b0;
    int   got;

    function automatic logic [N_LOG2-1:0] exp_addr(input int k);
        logic [N_LOG2-1:0] a;
        logic [N_LOG2-1:0] r;
        a = k[N_LOG2-1:0];
        for (int b = 0; b < N_LOG2; b++) r[b] = a[N_LOG2-1-b];
        return BITREV ? r : a;
    endfunction

    function automatic logic [2*DATA_W-1:0] sample(input int k);
        return {DATA_W'(k), DATA_W'(-k)};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (ram_en) begin
            writes++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h with none expected", ram_addr, ram_din);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(ram_addr), 64'(e.addr));
                check("wr_data", 64'(ram_din), 64'(e.data));
                check("wr_we", 64'(ram_we), 64'd1);
            end
        end
        if (fft_start) begin
            starts++;
            check("start_after_last_write", {62'd0, prev_en, exp_q.size() == 0}, 64'd3);
        end
        if (err_short) errs++;
        prev_en <= ram_en;
    end

    task automatic drive(input int first, input int n, input int last_idx, input bit gaps, output int accepted);
        int k = first;
        int budget = 0;
        while (k < first + n && budget < 20000) begin
            @(negedge clk);
            budget++;
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = sample(k);
            s_last  = (k == last_idx);
            if (s_valid && s_ready) begin
                exp_q.push_back('{exp_addr(k), sample(k)});
                if (s_last && (k % N) < N - 1)
                    for (int j = k % N + 1; j < N; j++) exp_q.push_back('{exp_addr(j), '0});
                k++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        accepted = k - first;
    endtask

    task automatic wait_start(input int target, input int limit);
        int c = 0;
        while (starts < target && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("start_seen", 64'(starts >= target), 64'd1);
    endtask

    task automatic hold_then_done(input int cycles);
        int bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("hold_in_wait", 64'(bad), 64'd0);
        fft_done = 1'b1;
        @(negedge clk);
        fft_done = 1'b0;
    endtask

    vec_t tbl[4];

    initial begin
        int s0, e0, w0;
        tbl[0] = '{"ramp",        1024, -1,   1'b0, 0};
        tbl[1] = '{"short99",     100,  99,   1'b0, 1};
        tbl[2] = '{"gaps",        1024, -1,   1'b1, 0};
        tbl[3] = '{"last_on_end", 1024, 1023, 1'b0, 0};

        @(negedge clk);
        check("ready_in_reset", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_din", 64'(ram_din), 64'd0);
        check("rst_fft_start", 64'(fft_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_short", 64'(err_short), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(s_ready), 64'd1);

        foreach (tbl[v]) begin
            s0 = starts; e0 = errs; w0 = writes;
            fft_done = 1'b1;
            @(negedge clk);
            fft_done = 1'b0;
            check({tbl[v].name, "_done_ignored"}, {62'd0, s_ready, busy}, 64'd2);
            drive(0, tbl[v].n, tbl[v].last_idx, tbl[v].gaps, got);
            check({tbl[v].name, "_accepted"}, 64'(got), 64'(tbl[v].n));
            wait_start(s0 + 1, 3000);
            hold_then_done(20);
            check({tbl[v].name, "_ready_after_done"}, 64'(s_ready), 64'd1);
            check({tbl[v].name, "_starts"}, 64'(starts - s0), 64'd1);
            check({tbl[v].name, "_errs"}, 64'(errs - e0), 64'(tbl[v].exp_err));
            check({tbl[v].name, "_writes"}, 64'(writes - w0), 64'(N));
            check({tbl[v].name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        end

        s0 = starts;
        drive(0, 500, -1, 1'b0, got);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_ready_in_reset", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midframe_no_start", 64'(starts - s0), 64'd0);
        check("midframe_queue_empty", 64'(exp_q.size()), 64'd0);
        w0 = writes;
        drive(0, 1024, -1, 1'b0, got);
        wait_start(s0 + 1, 3000);
        check("midframe_restart_writes", 64'(writes - w0), 64'(N));
        hold_then_done(5);

        s0 = starts;
        fork
            drive(0, 2 * N, -1, 1'b0, got);
            for (int f = 1; f <= 2; f++) begin
                wait_start(s0 + f, 3000);
                hold_then_done(20);
            end
        join
        check("b2b_accepted", 64'(got), 64'(2 * N));
        check("b2b_starts", 64'(starts - s0), 64'd2);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
